jk_bank_arbiter: RTL and testbench

Round-robin controller sharing one WIDTH-bit bank of master-slave JK flip-flops between N_REQ requesters. Each requester issues a masked HOLD/CLEAR/SET/TOGGLE operation over a req/done handshake. The arbiter drives the bank's J/K inputs for exactly one cycle per granted operation, then returns the updated bank value. It sits between the JK storage cells and the control logic that needs shared flag/state bits.

---
 rtl/jk_bank_arbiter_pkg.sv | 14 +
 rtl/jk_bank_arbiter_cell.sv | 28 ++
 rtl/jk_bank_arbiter.sv | 130 +++++++++++++
 tb/tb_jk_bank_arbiter.sv | 241 ++++++++++++++++++++++++
 4 files changed

// File: rtl/jk_bank_arbiter_pkg.sv
// Shared opcodes and FSM encoding for the JK bank arbiter.
package jk_bank_arbiter_pkg;
  localparam logic [1:0] OP_HOLD   = 2'b00;
  localparam logic [1:0] OP_CLEAR  = 2'b01;
  localparam logic [1:0] OP_SET    = 2'b10;
  localparam logic [1:0] OP_TOGGLE = 2'b11;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_APPLY  = 2'd1,
    ST_SETTLE = 2'd2,
    ST_ACK    = 2'd3
  } state_e;
endpackage

// File: rtl/jk_bank_arbiter_cell.sv
// Single JK storage bit; the bank is an array of these.
module jk_cell (
  input  logic clk,
  input  logic rst_n,
  input  logic j,
  input  logic k,
  output logic q,
  output logic q_bar
);
  logic q_q, q_d;

  always_comb begin
    case ({j, k})
      2'b00:   q_d = q_q;
      2'b01:   q_d = 1'b0;
      2'b10:   q_d = 1'b1;
      default: q_d = ~q_q;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) q_q <= 1'b0;
    else        q_q <= q_d;
  end

  assign q     = q_q;
  assign q_bar = ~q_q;
endmodule

// File: rtl/jk_bank_arbiter.sv
// Round-robin arbiter granting one masked JK op per 4 cycles onto a shared bank.
module jk_bank_arbiter
  import jk_bank_arbiter_pkg::*;
#(
  parameter int N_REQ = 4,
  parameter int WIDTH = 8
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic [N_REQ-1:0]       req,
  input  logic [2*N_REQ-1:0]     op,
  input  logic [WIDTH*N_REQ-1:0] mask,
  output logic [N_REQ-1:0]       gnt,
  output logic                   done,
  output logic                   busy,
  output logic [WIDTH-1:0]       q,
  output logic [WIDTH-1:0]       q_bar
);
  localparam int PW = (N_REQ > 1) ? $clog2(N_REQ) : 1;

  // Reset asserts asynchronously but releases on a clock edge.
  logic [1:0] rst_sync_q;
  logic       rst_i_n;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) rst_sync_q <= 2'b00;
    else        rst_sync_q <= {rst_sync_q[0], 1'b1};
  end
  assign rst_i_n = rst_sync_q[1];

  state_e             state_q, state_d;
  logic [PW-1:0]      ptr_q, ptr_d;
  logic [PW-1:0]      win_q, win_d;
  logic [N_REQ-1:0]   gnt_q, gnt_d;
  logic [1:0]         op_q, op_d;
  logic [WIDTH-1:0]   mask_q, mask_d;
  logic [WIDTH-1:0]   j_bank, k_bank;

  logic               found;
  logic [PW-1:0]      win_sel;
  int                 idx;

  // Priority search starting at ptr with modulo wrap.
  always_comb begin
    found   = 1'b0;
    win_sel = ptr_q;
    idx     = 0;
    for (int i = 0; i < N_REQ; i++) begin
      idx = (int'(ptr_q) + i) % N_REQ;
      if (!found && req[idx]) begin
        found   = 1'b1;
        win_sel = PW'(idx);
      end
    end
  end

  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    win_d   = win_q;
    gnt_d   = gnt_q;
    op_d    = op_q;
    mask_d  = mask_q;
    j_bank  = '0;
    k_bank  = '0;
    case (state_q)
      ST_IDLE: begin
        if (found) begin
          win_d   = win_sel;
          op_d    = op[2*int'(win_sel) +: 2];
          mask_d  = mask[WIDTH*int'(win_sel) +: WIDTH];
          gnt_d   = N_REQ'(1) << win_sel;
          state_d = ST_APPLY;
        end
      end
      ST_APPLY: begin
        case (op_q)
          OP_CLEAR:  k_bank = mask_q;
          OP_SET:    j_bank = mask_q;
          OP_TOGGLE: begin
            j_bank = mask_q;
            k_bank = mask_q;
          end
          default: ;
        endcase
        state_d = ST_SETTLE;
      end
      ST_SETTLE: state_d = ST_ACK;
      ST_ACK: begin
        ptr_d   = (win_q == PW'(N_REQ-1)) ? '0 : PW'(int'(win_q) + 1);
        gnt_d   = '0;
        state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_i_n) begin
    if (!rst_i_n) begin
      state_q <= ST_IDLE;
      ptr_q   <= '0;
      win_q   <= '0;
      gnt_q   <= '0;
      op_q    <= OP_HOLD;
      mask_q  <= '0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      win_q   <= win_d;
      gnt_q   <= gnt_d;
      op_q    <= op_d;
      mask_q  <= mask_d;
    end
  end

  for (genvar b = 0; b < WIDTH; b++) begin : g_bank
    jk_cell u_cell (
      .clk   (clk),
      .rst_n (rst_i_n),
      .j     (j_bank[b]),
      .k     (k_bank[b]),
      .q     (q[b]),
      .q_bar (q_bar[b])
    );
  end

  assign gnt  = gnt_q;
  assign done = (state_q == ST_ACK);
  assign busy = (state_q != ST_IDLE);
endmodule

// File: tb/tb_jk_bank_arbiter.sv
// Randomized + directed bench for jk_bank_arbiter against a set/clear/xor bank model.
module tb_jk_bank_arbiter;
  localparam int N = 4;
  localparam int W = 8;

  logic           clk;
  logic           rst_n;
  logic [N-1:0]   req;
  logic [2*N-1:0] op;
  logic [W*N-1:0] mask;
  logic [N-1:0]   gnt;
  logic           done, busy;
  logic [W-1:0]   q, q_bar;

  jk_bank_arbiter #(.N_REQ(N), .WIDTH(W)) dut (
    .clk(clk), .rst_n(rst_n), .req(req), .op(op), .mask(mask),
    .gnt(gnt), .done(done), .busy(busy), .q(q), .q_bar(q_bar)
  );

  always #5 clk = ~clk;

  int           checks = 0;
  int           fails  = 0;
  logic [1:0]   op_m   [N];
  logic [W-1:0] mask_m [N];
  logic [W-1:0] q_m;
  int           ptr_m;
  logic [N-1:0] last_gnt;

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    end
  endtask

  function automatic int pick(input logic [N-1:0] r, input int p);
    for (int i = 0; i < N; i++)
      if (r[(p + i) % N]) return (p + i) % N;
    return 0;
  endfunction

  function automatic logic [W-1:0] apply_op(input logic [W-1:0] cur, input logic [1:0] o,
                                            input logic [W-1:0] m);
    case (o)
      2'b01:   return cur & ~m;
      2'b10:   return cur | m;
      2'b11:   return cur ^ m;
      default: return cur;
    endcase
  endfunction

  task automatic drive();
    for (int i = 0; i < N; i++) begin
      op[2*i +: 2]   = op_m[i];
      mask[W*i +: W] = mask_m[i];
    end
  endtask

  // One full grant-to-idle transaction, checked cycle by cycle.
  task automatic serve(input bit b2b, input bit perturb, input bit drop);
    int n, w;
    logic [1:0]   lop;
    logic [W-1:0] lm, qn, nq;
    n = 1;
    @(negedge clk);
    while (gnt == '0 && n < 16) begin
      @(negedge clk);
      n++;
    end
    if (gnt == '0) begin
      chk("gnt_timeout", 32'(gnt), 32'(1));
      return;
    end
    w = pick(req, ptr_m);
    last_gnt = gnt;
    chk("gnt", 32'(gnt), 32'(1) << w);
    if (b2b) chk("gap", 32'(n), 32'(1));
    chk("busy", 32'(busy), 32'(1));
    lop = op_m[w];
    lm  = mask_m[w];
    qn  = apply_op(q_m, lop, lm);
    nq  = ~qn;
    if (perturb) begin
      op_m[w]   = 2'($urandom);
      mask_m[w] = 8'($urandom);
      req[w]    = 1'b0;
      drive();
    end
    @(negedge clk);
    chk("q_apply", 32'(q), 32'(qn));
    chk("done_early", 32'(done), 32'(0));
    @(negedge clk);
    chk("done", 32'(done), 32'(1));
    chk("q_ack", 32'(q), 32'(qn));
    chk("q_bar", 32'(q_bar), 32'(nq));
    chk("gnt_hold", 32'(gnt), 32'(1) << w);
    q_m   = qn;
    ptr_m = (w + 1) % N;
    if (drop) req[w] = 1'b0;
    @(negedge clk);
    chk("done_clr", 32'(done), 32'(0));
    chk("gnt_clr", 32'(gnt), 32'(0));
    chk("busy_clr", 32'(busy), 32'(0));
  endtask

  task automatic go(input int i, input logic [1:0] o, input logic [W-1:0] m);
    op_m[i]   = o;
    mask_m[i] = m;
    req[i]    = 1'b1;
    drive();
    serve(1'b0, 1'b0, 1'b1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1);
  end

  initial begin
    clk   = 1'b0;
    rst_n = 1'b1;
    req   = '0;
    for (int i = 0; i < N; i++) begin
      op_m[i]   = 2'b00;
      mask_m[i] = '0;
    end
    drive();
    q_m   = '0;
    ptr_m = 0;
    #2 rst_n = 1'b0;
    #1;
    chk("rst_q", 32'(q), 32'(0));
    chk("rst_qbar", 32'(q_bar), 32'hFF);
    chk("rst_gnt", 32'(gnt), 32'(0));
    chk("rst_done", 32'(done), 32'(0));
    chk("rst_busy", 32'(busy), 32'(0));
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    repeat (3) @(negedge clk);

    // Directed single ops on requester 0.
    go(0, 2'b10, 8'hF0); chk("set_f0",    32'(q), 32'hF0);
    go(0, 2'b11, 8'hFF); chk("toggle_ff", 32'(q), 32'h0F);
    go(0, 2'b01, 8'h0C); chk("clear_0c",  32'(q), 32'h03);
    go(0, 2'b00, 8'hFF); chk("hold_ff",   32'(q), 32'h03);

    // Pointer wrap: after serving 2, requester 0 beats 2.
    go(2, 2'b00, 8'h00);
    op_m[0] = 2'b10; mask_m[0] = 8'h11;
    op_m[2] = 2'b10; mask_m[2] = 8'h22;
    req = 4'b0101;
    drive();
    serve(1'b0, 1'b0, 1'b1);
    chk("wrap_first", 32'(last_gnt), 32'h1);
    serve(1'b1, 1'b0, 1'b1);
    chk("wrap_second", 32'(last_gnt), 32'h4);

    // Masked isolation on requester 1.
    go(1, 2'b01, 8'hFF);
    go(1, 2'b10, 8'h80);
    go(1, 2'b11, 8'h01);
    chk("iso", 32'(q), 32'h81);

    // Mid-op change: latched op must still apply.
    op_m[3] = 2'b10; mask_m[3] = 8'h3C;
    req[3]  = 1'b1;
    drive();
    serve(1'b0, 1'b1, 1'b1);
    chk("midop", 32'(q), 32'hBD);

    // Reset mid-APPLY with q = A5.
    go(1, 2'b01, 8'hFF);
    go(1, 2'b10, 8'hA5);
    chk("pre_rst", 32'(q), 32'hA5);
    op_m[1] = 2'b11; mask_m[1] = 8'hFF;
    req[1]  = 1'b1;
    drive();
    begin
      int n = 0;
      while (gnt == '0 && n < 16) begin
        @(negedge clk);
        n++;
      end
    end
    chk("rst_mid_busy", 32'(busy), 32'(1));
    rst_n = 1'b0;
    #1;
    chk("mid_rst_q", 32'(q), 32'(0));
    chk("mid_rst_qbar", 32'(q_bar), 32'hFF);
    chk("mid_rst_gnt", 32'(gnt), 32'(0));
    chk("mid_rst_done", 32'(done), 32'(0));
    req = '0;
    @(negedge clk);
    rst_n = 1'b1;
    q_m   = '0;
    ptr_m = 0;
    for (int c = 0; c < 6; c++) begin
      @(negedge clk);
      chk("no_done_after_rst", 32'(done), 32'(0));
    end

    // Round-robin with all requests held from reset.
    rst_n = 1'b0;
    req   = 4'b1111;
    for (int i = 0; i < N; i++) begin
      op_m[i]   = 2'($urandom);
      mask_m[i] = 8'($urandom);
    end
    drive();
    q_m   = '0;
    ptr_m = 0;
    @(negedge clk);
    rst_n = 1'b1;
    for (int k = 0; k < 5; k++) begin
      serve(k != 0, 1'b0, 1'b0);
      chk("rr_seq", 32'(last_gnt), 32'(1) << (k % N));
    end
    req = '0;
    repeat (2) @(negedge clk);

    // Random phase.
    for (int it = 0; it < 30; it++) begin
      int cnt;
      req = 4'($urandom_range(1, 15));
      for (int i = 0; i < N; i++) begin
        op_m[i]   = 2'($urandom);
        mask_m[i] = 8'($urandom);
      end
      drive();
      cnt = $countones(req);
      for (int k = 0; k < cnt; k++)
        serve(1'b1, 1'($urandom_range(0, 3) == 0), 1'b1);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, fails);
    $finish;
  end
endmodule
